// File: rtl/mm_stage_ctrl_pkg.sv
// Shared definitions for the EX->MM stage controller.
// Bus widths and the memory-response tracker state encoding.
package mm_stage_ctrl_pkg;

    localparam int MM_LINE_W    = 160;
    localparam int MM_DATA_W    = 32;
    localparam int MM_EX_BUS_W  = 2 * MM_LINE_W;
    localparam int MM_TO_NEXT_W = 2 * MM_LINE_W + MM_DATA_W;

    typedef enum logic [1:0] {
        MM_IDLE   = 2'd0,
        MM_WAIT   = 2'd1,
        MM_HOLD   = 2'd2,
        MM_CANCEL = 2'd3
    } mm_state_t;

endpackage

// File: rtl/mm_stage_ctrl_if.sv
// EX->MM handshake: lane valids, buses and lane-1 request flag
// from EX (master); allowin and occupancy back from MM (slave).
interface mm_stage_ctrl_if
    import mm_stage_ctrl_pkg::*;
#(
    parameter int LINE_W = MM_LINE_W
);
    logic                  line1_pre_to_now_valid_i;
    logic                  line2_pre_to_now_valid_i;
    logic                  line1_mem_req_i;
    logic [2*LINE_W-1:0]   pre_to_ibus;
    logic                  now_allowin_o;
    logic                  next_stages_valid_o;

    modport master (
        output line1_pre_to_now_valid_i,
        output line2_pre_to_now_valid_i,
        output line1_mem_req_i,
        output pre_to_ibus,
        input  now_allowin_o,
        input  next_stages_valid_o
    );

    modport slave (
        input  line1_pre_to_now_valid_i,
        input  line2_pre_to_now_valid_i,
        input  line1_mem_req_i,
        input  pre_to_ibus,
        output now_allowin_o,
        output next_stages_valid_o
    );

endinterface

// File: rtl/mm_stage_ctrl_resp_tracker.sv
// Data-SRAM response tracker: FSM, read-data buffer and ready_go.
// Ports: clk/rst, flush, captured-request strobe, lane-1 pending, data_ok/rdata, state/ready_go/rdata out.
module mm_resp_tracker
    import mm_stage_ctrl_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              cap_req_i,
    input  logic              l1_pending_i,
    input  logic              next_allowin_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    output mm_state_t         state_o,
    output logic              ready_go_o,
    output logic [DATA_W-1:0] rdata_o
);

    mm_state_t         state;
    mm_state_t         state_nxt;
    logic              buf_load;
    logic [DATA_W-1:0] rdata_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MM_IDLE;
            rdata_buf <= '0;
        end else begin
            state <= state_nxt;
            if (buf_load) begin
                rdata_buf <= rdata_i;
            end
        end
    end

    // cap_req_i already excludes flush cycles, so a release that
    // coincides with a new load capture goes straight back to WAIT.
    always_comb begin
        state_nxt = state;
        buf_load  = 1'b0;
        unique case (state)
            MM_IDLE: begin
                if (cap_req_i) begin
                    state_nxt = MM_WAIT;
                end
            end
            MM_WAIT: begin
                if (flush_i) begin
                    state_nxt = data_ok_i ? MM_IDLE : MM_CANCEL;
                end else if (data_ok_i) begin
                    if (!next_allowin_i) begin
                        state_nxt = MM_HOLD;
                        buf_load  = 1'b1;
                    end else begin
                        state_nxt = cap_req_i ? MM_WAIT : MM_IDLE;
                    end
                end
            end
            MM_HOLD: begin
                if (flush_i) begin
                    state_nxt = MM_IDLE;
                end else if (next_allowin_i) begin
                    state_nxt = cap_req_i ? MM_WAIT : MM_IDLE;
                end
            end
            MM_CANCEL: begin
                // The outstanding response is stale; swallow it.
                if (flush_i || data_ok_i) begin
                    state_nxt = MM_IDLE;
                end
            end
            default: state_nxt = MM_IDLE;
        endcase
    end

    assign state_o    = state;
    assign ready_go_o = !l1_pending_i
                     || (state == MM_HOLD)
                     || (state == MM_WAIT && data_ok_i);
    assign rdata_o    = (state == MM_WAIT && data_ok_i) ? rdata_i : rdata_buf;

endmodule

// File: rtl/mm_stage_ctrl.sv
// Dual-lane EX->MM pipeline register with data-SRAM response hold.
// Ports: clk/rst, EX handshake (ex), downstream allowin/valids, flush, SRAM data_ok/rdata, to_next_obus.
module mm_stage_ctrl
    import mm_stage_ctrl_pkg::*;
#(
    parameter int LINE_W = MM_LINE_W,
    parameter int DATA_W = MM_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    mm_stage_ctrl_if.slave               ex,
    input  logic                         next_allowin_i,
    output logic                         line1_now_to_next_valid_o,
    output logic                         line2_now_to_next_valid_o,
    input  logic                         excep_flush_i,
    input  logic                         data_sram_data_ok_i,
    input  logic [DATA_W-1:0]            data_sram_rdata_i,
    output logic [2*LINE_W+DATA_W-1:0]   to_next_obus
);

    logic              l1_v;
    logic              l2_v;
    logic              l1_req;
    logic [LINE_W-1:0] l1_bus;
    logic [LINE_W-1:0] l2_bus;
    logic              cap;
    logic              cap_req;
    logic              ready_go;
    logic [DATA_W-1:0] rdata;
    mm_state_t         state;

    assign cap     = ex.now_allowin_o && !excep_flush_i;
    assign cap_req = cap && ex.line1_pre_to_now_valid_i && ex.line1_mem_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            l1_v   <= 1'b0;
            l2_v   <= 1'b0;
            l1_req <= 1'b0;
            l1_bus <= '0;
            l2_bus <= '0;
        end else if (excep_flush_i) begin
            l1_v <= 1'b0;
            l2_v <= 1'b0;
        end else if (cap) begin
            l1_v <= ex.line1_pre_to_now_valid_i;
            l2_v <= ex.line2_pre_to_now_valid_i;
            if (ex.line1_pre_to_now_valid_i) begin
                l1_bus <= ex.pre_to_ibus[LINE_W-1:0];
                l1_req <= ex.line1_mem_req_i;
            end
            if (ex.line2_pre_to_now_valid_i) begin
                l2_bus <= ex.pre_to_ibus[2*LINE_W-1:LINE_W];
            end
        end
    end

    mm_resp_tracker #(
        .DATA_W (DATA_W)
    ) u_trk (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (excep_flush_i),
        .cap_req_i      (cap_req),
        .l1_pending_i   (l1_v && l1_req),
        .next_allowin_i (next_allowin_i),
        .data_ok_i      (data_sram_data_ok_i),
        .rdata_i        (data_sram_rdata_i),
        .state_o        (state),
        .ready_go_o     (ready_go),
        .rdata_o        (rdata)
    );

    assign ex.now_allowin_o = (state != MM_CANCEL)
                           && (!(l1_v || l2_v) || (ready_go && next_allowin_i));

    // Cancelling still counts as occupied so EX holds off new requests.
    assign ex.next_stages_valid_o = l1_v || l2_v || (state == MM_CANCEL);

    assign line1_now_to_next_valid_o = l1_v && ready_go && !excep_flush_i;
    assign line2_now_to_next_valid_o = l2_v && ready_go && !excep_flush_i;

    assign to_next_obus = {rdata, l2_bus, l1_bus};

endmodule

// File: tb/tb_mm_stage_ctrl.sv
// Testbench for mm_stage_ctrl: scoreboard of expected lane outputs.
// Ports: none (drives clk, rst, the EX interface and the SRAM/downstream side).
module tb_mm_stage_ctrl;
    import mm_stage_ctrl_pkg::*;

    localparam int LW = MM_LINE_W;
    localparam int DW = MM_DATA_W;

    typedef struct {
        logic [LW-1:0] bus;
        logic [DW-1:0] rdata;
        logic          chk_rd;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                next_allowin_i;
    logic                line1_now_to_next_valid_o;
    logic                line2_now_to_next_valid_o;
    logic                excep_flush_i;
    logic                data_sram_data_ok_i;
    logic [DW-1:0]       data_sram_rdata_i;
    logic [2*LW+DW-1:0]  to_next_obus;

    mm_stage_ctrl_if #(.LINE_W(LW)) ex_if ();

    mm_stage_ctrl #(
        .LINE_W (LW),
        .DATA_W (DW)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .ex                        (ex_if),
        .next_allowin_i            (next_allowin_i),
        .line1_now_to_next_valid_o (line1_now_to_next_valid_o),
        .line2_now_to_next_valid_o (line2_now_to_next_valid_o),
        .excep_flush_i             (excep_flush_i),
        .data_sram_data_ok_i       (data_sram_data_ok_i),
        .data_sram_rdata_i         (data_sram_rdata_i),
        .to_next_obus              (to_next_obus)
    );

    always #5 clk = ~clk;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;
    int   n_checks = 0;
    int   n_err    = 0;

    logic [DW-1:0] rd_field;
    assign rd_field = to_next_obus[2*LW +: DW];

    task automatic check(input string tag, input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfers happen when a lane is valid and downstream accepts.
    always @(negedge clk) begin
        if (!rst && next_allowin_i) begin
            if (line1_now_to_next_valid_o) begin
                if (q1.size() == 0) begin
                    check("l1_unexpected", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    check("l1_bus", to_next_obus[LW-1:0], e1.bus);
                    if (e1.chk_rd) check("l1_rdata", LW'(rd_field), LW'(e1.rdata));
                end
            end
            if (line2_now_to_next_valid_o) begin
                if (q2.size() == 0) begin
                    check("l2_unexpected", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    check("l2_bus", to_next_obus[2*LW-1:LW], e2.bus);
                end
            end
        end
    end

    function automatic logic [LW-1:0] rnd_bus();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic v1, input logic v2, input logic req,
                            input logic [LW-1:0] b1, input logic [LW-1:0] b2);
        ex_if.line1_pre_to_now_valid_i = v1;
        ex_if.line2_pre_to_now_valid_i = v2;
        ex_if.line1_mem_req_i          = req;
        ex_if.pre_to_ibus              = {b2, b1};
    endtask

    task automatic ex_idle();
        ex_drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    logic [LW-1:0] b1;
    logic [LW-1:0] b2;

    // Capture one lane-1 load (optional lane 2 ALU op) this cycle.
    task automatic cap_load(input logic with_l2, input logic [DW-1:0] rd,
                            input logic expect_out);
        b1 = rnd_bus();
        b2 = rnd_bus();
        ex_drive(1'b1, with_l2, 1'b1, b1, b2);
        #1;
        check("cap_allowin", ex_if.now_allowin_o, 1);
        if (expect_out) begin
            q1.push_back('{bus: b1, rdata: rd, chk_rd: 1'b1});
            if (with_l2) q2.push_back('{bus: b2, rdata: '0, chk_rd: 1'b0});
        end
        tick();
        ex_idle();
    endtask

    initial begin
        rst                 = 1'b1;
        next_allowin_i      = 1'b1;
        excep_flush_i       = 1'b0;
        data_sram_data_ok_i = 1'b0;
        data_sram_rdata_i   = '0;
        ex_idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_allowin", ex_if.now_allowin_o, 1);
        check("rst_v1", line1_now_to_next_valid_o, 0);
        check("rst_v2", line2_now_to_next_valid_o, 0);
        check("rst_nsv", ex_if.next_stages_valid_o, 0);
        check("rst_obus_l1", to_next_obus[LW-1:0], 0);
        check("rst_obus_l2", to_next_obus[2*LW-1:LW], 0);
        check("rst_obus_rd", LW'(rd_field), 0);

        // Back-to-back ALU pairs, no memory request.
        for (int i = 0; i < 3; i++) begin
            b1 = rnd_bus();
            b2 = rnd_bus();
            ex_drive(1'b1, 1'b1, 1'b0, b1, b2);
            q1.push_back('{bus: b1, rdata: '0, chk_rd: 1'b0});
            q2.push_back('{bus: b2, rdata: '0, chk_rd: 1'b0});
            #1;
            check("alu_allowin", ex_if.now_allowin_o, 1);
            if (i > 0) begin
                check("alu_v1", line1_now_to_next_valid_o, 1);
                check("alu_v2", line2_now_to_next_valid_o, 1);
            end
            tick();
        end
        ex_idle();
        #1;
        check("alu_last_v1", line1_now_to_next_valid_o, 1);
        check("alu_last_v2", line2_now_to_next_valid_o, 1);
        tick();
        check("alu_drained", ex_if.next_stages_valid_o, 0);

        // Load, response three cycles later.
        cap_load(1'b1, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_wait_v1", line1_now_to_next_valid_o, 0);
            check("ld_wait_v2", line2_now_to_next_valid_o, 0);
            check("ld_wait_allowin", ex_if.now_allowin_o, 0);
            check("ld_wait_nsv", ex_if.next_stages_valid_o, 1);
            tick();
        end
        data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i   = 32'hDEADBEEF;
        #1;
        check("ld_ok_v1", line1_now_to_next_valid_o, 1);
        check("ld_ok_allowin", ex_if.now_allowin_o, 1);
        check("ld_ok_rdata", LW'(rd_field), LW'(32'hDEADBEEF));
        tick();
        data_sram_data_ok_i = 1'b0;
        data_sram_rdata_i   = '0;
        #1;
        check("ld_done_nsv", ex_if.next_stages_valid_o, 0);
        tick();

        // Response while downstream stalls: held from the buffer.
        cap_load(1'b0, 32'hDEADBEEF, 1'b1);
        next_allowin_i      = 1'b0;
        data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i   = 32'hDEADBEEF;
        #1;
        check("hold_ok_v1", line1_now_to_next_valid_o, 1);
        check("hold_ok_allowin", ex_if.now_allowin_o, 0);
        tick();
        data_sram_data_ok_i = 1'b0;
        data_sram_rdata_i   = '0;
        #1;
        check("hold_v1", line1_now_to_next_valid_o, 1);
        check("hold_allowin", ex_if.now_allowin_o, 0);
        check("hold_rdata", LW'(rd_field), LW'(32'hDEADBEEF));
        tick();
        next_allowin_i = 1'b1;
        #1;
        check("hold_rel_allowin", ex_if.now_allowin_o, 1);
        tick();
        check("hold_done_nsv", ex_if.next_stages_valid_o, 0);
        tick();

        // Flush while waiting: cancel until the stale response.
        cap_load(1'b0, '0, 1'b0);
        excep_flush_i = 1'b1;
        #1;
        check("fl_v1", line1_now_to_next_valid_o, 0);
        tick();
        excep_flush_i = 1'b0;
        ex_drive(1'b1, 1'b1, 1'b0, rnd_bus(), rnd_bus());
        #1;
        check("cancel_allowin", ex_if.now_allowin_o, 0);
        check("cancel_nsv", ex_if.next_stages_valid_o, 1);
        check("cancel_v1", line1_now_to_next_valid_o, 0);
        tick();
        data_sram_data_ok_i = 1'b1;
        #1;
        check("cancel_ok_allowin", ex_if.now_allowin_o, 0);
        check("cancel_ok_nsv", ex_if.next_stages_valid_o, 1);
        tick();
        data_sram_data_ok_i = 1'b0;
        ex_idle();
        #1;
        check("cancel_end_allowin", ex_if.now_allowin_o, 1);
        check("cancel_end_nsv", ex_if.next_stages_valid_o, 0);
        tick();

        // Flush with data_ok and a new incoming pair.
        cap_load(1'b0, '0, 1'b0);
        excep_flush_i       = 1'b1;
        data_sram_data_ok_i = 1'b1;
        ex_drive(1'b1, 1'b1, 1'b1, rnd_bus(), rnd_bus());
        #1;
        check("flok_v1", line1_now_to_next_valid_o, 0);
        check("flok_v2", line2_now_to_next_valid_o, 0);
        tick();
        excep_flush_i       = 1'b0;
        data_sram_data_ok_i = 1'b0;
        ex_idle();
        #1;
        check("flok_nsv", ex_if.next_stages_valid_o, 0);
        check("flok_allowin", ex_if.now_allowin_o, 1);
        tick();

        // Reset while waiting, then a stray response.
        cap_load(1'b1, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstw_v1", line1_now_to_next_valid_o, 0);
        check("rstw_v2", line2_now_to_next_valid_o, 0);
        check("rstw_allowin", ex_if.now_allowin_o, 1);
        check("rstw_nsv", ex_if.next_stages_valid_o, 0);
        check("rstw_obus_l1", to_next_obus[LW-1:0], 0);
        data_sram_data_ok_i = 1'b1;
        data_sram_rdata_i   = 32'h55AA55AA;
        #1;
        check("stray_rdata", LW'(rd_field), 0);
        check("stray_nsv", ex_if.next_stages_valid_o, 0);
        tick();
        data_sram_data_ok_i = 1'b0;
        data_sram_rdata_i   = '0;
        #1;
        check("stray_after_nsv", ex_if.next_stages_valid_o, 0);
        check("stray_after_allowin", ex_if.now_allowin_o, 1);

        // Normal single-lane ALU op still flows after all that.
        b1 = rnd_bus();
        ex_drive(1'b1, 1'b0, 1'b0, b1, '0);
        q1.push_back('{bus: b1, rdata: '0, chk_rd: 1'b0});
        tick();
        ex_idle();
        #1;
        check("tail_v1", line1_now_to_next_valid_o, 1);
        check("tail_v2", line2_now_to_next_valid_o, 0);
        tick();
        tick();

        check("q1_empty", LW'(q1.size()), 0);
        check("q2_empty", LW'(q2.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
